// File: rtl/button_cmd_scheduler.sv
// rtl/button_cmd_scheduler.sv - debounced buttons to short/long command tokens with rr arbitration and FIFO
//
// Purpose:
//   Watches debounced button levels and classifies each press as short or long.
//   Each classified press raises a pending flag for its button. A round-robin
//   arbiter moves one pending flag per cycle into a small command FIFO.
//   The FIFO head is presented on a valid/ready interface.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   btn_db     debounced button levels, synchronous to clk
//   clr_err    clears the sticky dropped flag (a drop in the same cycle wins)
//   cmd_valid  FIFO head holds a command
//   cmd_ready  consumer accepts the head this cycle
//   cmd_id     button index of the head command (registered)
//   cmd_long   1 = long press, 0 = short press (registered)
//   dropped    sticky: an event hit an already-set pending flag and was lost

module button_cmd_scheduler #(
  parameter int NUM_BTN    = 4,
  parameter int LONG_CNT   = 50000000,
  parameter int CNT_W      = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_db,
  input  logic                       clr_err,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [$clog2(NUM_BTN)-1:0] cmd_id,
  output logic                       cmd_long,
  output logic                       dropped
);

  localparam int ID_W  = $clog2(NUM_BTN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] LONG_VAL = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_BTN - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  // Per-button press tracking
  logic [NUM_BTN-1:0] btn_prev;
  logic [NUM_BTN-1:0] armed;
  logic [NUM_BTN-1:0] long_done;
  logic [CNT_W-1:0]   hold_cnt [NUM_BTN];

  // Pending events waiting for arbitration
  logic [NUM_BTN-1:0] long_pend;
  logic [NUM_BTN-1:0] short_pend;

  // Round-robin pointer: first button searched next cycle
  logic [ID_W-1:0] rr;

  // Command FIFO, entries are {id, long}
  logic [ID_W:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   fifo_cnt;

  // Combinational event / arbitration signals
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] long_ev;
  logic [NUM_BTN-1:0] short_ev;
  logic [NUM_BTN-1:0] long_clr;
  logic [NUM_BTN-1:0] short_clr;
  logic               drop_any;

  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic               grant_long;
  int                 arb_idx;

  logic               push;
  logic               pop;
  logic [ID_W:0]      push_data;
  logic [PTR_W-1:0]   rd_nxt;
  logic [PTR_W:0]     cnt_nxt;
  logic [ID_W:0]      head_nxt;

  // ---------------------------------------------------------------------------
  // Press classification
  // ---------------------------------------------------------------------------
  always_comb begin
    rise     = '0;
    long_ev  = '0;
    short_ev = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rise[i]     = btn_db[i] & ~btn_prev[i];
      // Long fires on the sample that takes the counter from LONG_CNT-1 to
      // LONG_CNT; once saturated the equality never matches again.
      long_ev[i]  = armed[i] & btn_db[i] & (hold_cnt[i] == LONG_M1);
      short_ev[i] = armed[i] & ~btn_db[i] & ~long_done[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter, only while the FIFO has room before this cycle's pop
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_vld  = 1'b0;
    grant_id   = '0;
    grant_long = 1'b0;
    arb_idx    = 0;
    if (fifo_cnt < FULL_CNT) begin
      for (int k = 0; k < NUM_BTN; k++) begin
        arb_idx = int'(rr) + k;
        if (arb_idx >= NUM_BTN) arb_idx = arb_idx - NUM_BTN;
        if (!grant_vld && (long_pend[arb_idx] || short_pend[arb_idx])) begin
          grant_vld  = 1'b1;
          grant_id   = ID_W'(arb_idx);
          grant_long = long_pend[arb_idx];
        end
      end
    end
  end

  // A flag being granted this cycle is free to take a new event without loss.
  always_comb begin
    long_clr  = '0;
    short_clr = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      long_clr[i]  = grant_vld &  grant_long & (grant_id == ID_W'(i));
      short_clr[i] = grant_vld & ~grant_long & (grant_id == ID_W'(i));
    end
    drop_any = |((long_ev  & long_pend  & ~long_clr) |
                 (short_ev & short_pend & ~short_clr));
  end

  // ---------------------------------------------------------------------------
  // FIFO next-state; head outputs are registered from the post-edge head slot
  // ---------------------------------------------------------------------------
  always_comb begin
    push      = grant_vld;
    pop       = cmd_valid & cmd_ready;
    push_data = {grant_id, grant_long};
    rd_nxt    = rd_ptr + PTR_W'(pop);
    cnt_nxt   = fifo_cnt + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    // If the write slot is the new head the FIFO was empty after the pop, so
    // the pushed entry bypasses the memory straight to the head registers.
    if (push && (wr_ptr == rd_nxt)) head_nxt = push_data;
    else                            head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // All ones so a button held through reset needs a fresh press.
      btn_prev   <= '1;
      armed      <= '0;
      long_done  <= '0;
      long_pend  <= '0;
      short_pend <= '0;
      for (int i = 0; i < NUM_BTN; i++) hold_cnt[i] <= '0;
      rr         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      cmd_valid  <= 1'b0;
      cmd_id     <= '0;
      cmd_long   <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        btn_prev[i] <= btn_db[i];
        if (rise[i]) begin
          armed[i]     <= 1'b1;
          long_done[i] <= 1'b0;
          hold_cnt[i]  <= CNT_ONE;
        end else if (armed[i] && btn_db[i]) begin
          if (hold_cnt[i] != LONG_VAL) hold_cnt[i] <= hold_cnt[i] + CNT_ONE;
          if (long_ev[i]) long_done[i] <= 1'b1;
        end else if (armed[i]) begin
          armed[i]     <= 1'b0;
          long_done[i] <= 1'b0;
          hold_cnt[i]  <= '0;
        end
        long_pend[i]  <= (long_pend[i]  & ~long_clr[i])  | long_ev[i];
        short_pend[i] <= (short_pend[i] & ~short_clr[i]) | short_ev[i];
      end

      if (grant_vld) begin
        rr     <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      rd_ptr    <= rd_nxt;
      fifo_cnt  <= cnt_nxt;
      cmd_valid <= (cnt_nxt != '0);
      cmd_id    <= head_nxt[ID_W:1];
      cmd_long  <= head_nxt[0];

      if (drop_any)     dropped <= 1'b1;
      else if (clr_err) dropped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// tb/tb_button_cmd_scheduler.sv - scenario and randomized checks of button_cmd_scheduler against a queue model
module tb_button_cmd_scheduler;

  localparam int NB = 4;
  localparam int LC = 8;
  localparam int CW = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn_db = '0;
  logic          clr_err = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [1:0]    cmd_id;
  logic          cmd_long;
  logic          dropped;

  button_cmd_scheduler #(
    .NUM_BTN(NB), .LONG_CNT(LC), .CNT_W(CW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .btn_db(btn_db), .clr_err(clr_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_long(cmd_long), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic short_press(input int b);
    btn_db[b] = 1'b1;
    wait_cyc(1);
    btn_db[b] = 1'b0;
    wait_cyc(1);
  endtask

  // Behavioural model: run length of high samples per button, pending bits,
  // a queue of {id,long} commands, and a round-robin start index.
  int m_held [NB];
  bit m_prev [NB];
  bit m_lp   [NB];
  bit m_sp   [NB];
  int m_rr;
  int m_q[$];
  bit m_drop;

  int g;
  bit gl;
  bit ev_l, ev_s, drop_now, pop_now;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_held[i] = 0; m_prev[i] = 1'b1; m_lp[i] = 1'b0; m_sp[i] = 1'b0;
      end
      m_rr = 0;
      m_q.delete();
      m_drop = 1'b0;
    end else begin
      g = -1;
      gl = 1'b0;
      if (m_q.size() < FD) begin
        for (int k = 0; k < NB; k++) begin
          if (g < 0 && (m_lp[(m_rr + k) % NB] || m_sp[(m_rr + k) % NB])) begin
            g = (m_rr + k) % NB;
            gl = m_lp[g];
          end
        end
      end
      pop_now = (m_q.size() != 0) && cmd_ready;
      if (pop_now) void'(m_q.pop_front());
      if (g >= 0) begin
        m_q.push_back(g * 2 + int'(gl));
        if (gl) m_lp[g] = 1'b0; else m_sp[g] = 1'b0;
        m_rr = (g + 1) % NB;
      end
      drop_now = 1'b0;
      for (int i = 0; i < NB; i++) begin
        ev_l = 1'b0;
        ev_s = 1'b0;
        if (btn_db[i] && !m_prev[i]) begin
          m_held[i] = 1;
        end else if (m_held[i] > 0 && btn_db[i]) begin
          m_held[i]++;
          if (m_held[i] == LC) ev_l = 1'b1;
        end else if (m_held[i] > 0) begin
          if (m_held[i] < LC) ev_s = 1'b1;
          m_held[i] = 0;
        end
        m_prev[i] = btn_db[i];
        if (ev_l) begin
          if (m_lp[i]) drop_now = 1'b1; else m_lp[i] = 1'b1;
        end
        if (ev_s) begin
          if (m_sp[i]) drop_now = 1'b1; else m_sp[i] = 1'b1;
        end
      end
      if (drop_now)     m_drop = 1'b1;
      else if (clr_err) m_drop = 1'b0;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_valid", cmd_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("model_id", cmd_id, m_q[0] >> 1);
        chk("model_long", cmd_long, m_q[0] & 1);
      end
      chk("model_dropped", dropped, m_drop);
    end
  end

  int exp_ids [5] = '{0, 1, 2, 3, 0};

  initial begin
    #1;
    rst = 1'b1;
    btn_db = 4'b0001;
    wait_cyc(3);
    chk("reset_valid", cmd_valid, 0);
    chk("reset_id", cmd_id, 0);
    chk("reset_long", cmd_long, 0);
    chk("reset_dropped", dropped, 0);
    cmp_en = 1'b1;

    // Button held through reset is ignored
    rst = 1'b0;
    wait_cyc(3);
    btn_db[0] = 1'b0;
    wait_cyc(20);
    chk("s1_held_ignored", cmd_valid, 0);
    cmd_ready = 1'b1;
    btn_db[0] = 1'b1;
    wait_cyc(3);
    btn_db[0] = 1'b0;
    wait_cyc(1);
    chk("s1_latency_early", cmd_valid, 0);
    wait_cyc(1);
    chk("s1_valid", cmd_valid, 1);
    chk("s1_id", cmd_id, 0);
    chk("s1_long", cmd_long, 0);
    wait_cyc(1);
    chk("s1_one_cycle", cmd_valid, 0);

    // Long press, no short on release; LONG_CNT-1 hold is short
    btn_db[1] = 1'b1;
    wait_cyc(8);
    chk("s2_long_early", cmd_valid, 0);
    wait_cyc(1);
    chk("s2_long_valid", cmd_valid, 1);
    chk("s2_long_id", cmd_id, 1);
    chk("s2_long_flag", cmd_long, 1);
    wait_cyc(3);
    btn_db[1] = 1'b0;
    wait_cyc(4);
    chk("s2_no_short", cmd_valid, 0);
    btn_db[1] = 1'b1;
    wait_cyc(7);
    btn_db[1] = 1'b0;
    wait_cyc(2);
    chk("s2_short_valid", cmd_valid, 1);
    chk("s2_short_id", cmd_id, 1);
    chk("s2_short_flag", cmd_long, 0);
    wait_cyc(2);

    // Reset to bring rr back to 0, then simultaneous releases
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(1);
    btn_db = 4'b1111;
    wait_cyc(2);
    btn_db = 4'b0000;
    wait_cyc(1);
    chk("s3_early", cmd_valid, 0);
    for (int k = 0; k < 4; k++) begin
      wait_cyc(1);
      chk("s3_valid", cmd_valid, 1);
      chk("s3_id", cmd_id, k);
    end
    wait_cyc(1);
    chk("s3_empty", cmd_valid, 0);

    // Full FIFO, held pending flag, then a drop, then drain
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) short_press(i);
    short_press(0);
    wait_cyc(1);
    chk("s4_full_valid", cmd_valid, 1);
    chk("s4_head_stable", cmd_id, 0);
    chk("s4_no_drop", dropped, 0);
    short_press(0);
    chk("s4_dropped", dropped, 1);
    cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("s4_drain_valid", cmd_valid, 1);
      chk("s4_drain_id", cmd_id, exp_ids[k]);
      wait_cyc(1);
    end
    chk("s4_drained", cmd_valid, 0);

    // clr_err without and with a simultaneous drop
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    chk("s6_clear", dropped, 0);
    cmd_ready = 1'b0;
    repeat (5) short_press(0);
    btn_db[0] = 1'b1;
    wait_cyc(1);
    btn_db[0] = 1'b0;
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    chk("s6_set_wins", dropped, 1);

    // Asynchronous reset with a full FIFO and a pending flag
    chk("s5_pre_valid", cmd_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_async_clear", cmd_valid, 0);
    wait_cyc(2);
    rst = 1'b0;
    cmd_ready = 1'b1;
    wait_cyc(10);
    chk("s5_no_cmds", cmd_valid, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 5) == 0) btn_db[i] = ~btn_db[i];
      if (n < 2000) cmd_ready = ($urandom_range(0, 1) == 0);
      else          cmd_ready = ($urandom_range(0, 7) == 0);
      clr_err = ($urandom_range(0, 31) == 0);
      wait_cyc(1);
    end
    btn_db = '0;
    clr_err = 1'b0;
    cmd_ready = 1'b1;
    wait_cyc(30);
    chk("final_empty", cmd_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_cmd_scheduler.md
Name: button_cmd_scheduler

Overview:
- Converts debounced push-button levels into single-cycle command tokens for the systolic-array demo controller.
- Sits between the per-button debouncers and the top-level array sequencer (start / step / mode / load).
- Per button: detects short and long presses. Round-robin arbitrates between buttons with simultaneous events.
- Buffers tokens in a small FIFO with a valid/ready output handshake.

Parameters:
- NUM_BTN, 4, number of debounced button inputs (2..8).
- LONG_CNT, 50000000, consecutive held cycles that qualify a long press (0.5 s at 100 MHz); must be >= 2.
- CNT_W, 26, hold-counter width; must satisfy 2^CNT_W > LONG_CNT.
- FIFO_DEPTH, 4, command FIFO entries (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_db  in  NUM_BTN  debounced button levels, already synchronous to clk.
- clr_err  in  1  clears the dropped flag.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  consumer accepts the head this cycle.
- cmd_id  out  $clog2(NUM_BTN)  button index of the head command.
- cmd_long  out  1  1 = long press, 0 = short press.
- dropped  out  1  sticky flag: an event was lost.

Behaviour:
- Reset (async): cmd_valid=0, cmd_id=0, cmd_long=0, dropped=0. FIFO empty, all pending flags 0, rr pointer 0, hold counters 0, armed=0.
- Reset also sets btn_prev to all ones, so a button held through reset is ignored until it is released and pressed again.
- Press detect, per button i:
  - Rising edge (btn_db[i]=1, btn_prev[i]=0) sets armed[i] and loads hold_cnt[i]=1.
  - While armed and held, hold_cnt increments and saturates at LONG_CNT.
- Long press:
  - Fires in the cycle hold_cnt reaches LONG_CNT, i.e. after LONG_CNT consecutive high samples.
  - Sets long_pend[i] once and sets long_done[i].
  - No further long events for the same press.
- Release (btn_db[i]=0 while armed):
  - If long_done[i]=0, sets short_pend[i].
  - Clears armed, long_done and hold_cnt.
  - A press held exactly LONG_CNT-1 cycles is a short press.
- Drop: an event whose pending flag is already 1 is discarded and sets dropped=1.
- Arbitration, one grant per cycle:
  - Eligible only when FIFO count < FIFO_DEPTH, evaluated before this cycle's pop.
  - Searches buttons rr, rr+1, ... mod NUM_BTN for the first with any pending flag.
  - Within a button, long_pend is granted before short_pend.
  - Grant writes {id, long} to FIFO, clears that pending flag, and sets rr = (grant+1) mod NUM_BTN.
  - No grant leaves rr unchanged.
- A pending flag set in cycle t is grantable in cycle t+1.
- Latency: event sampled at edge t → FIFO write at edge t+1 → cmd_valid=1 after edge t+1 when the FIFO was empty (2 edges after the event edge).
- FIFO:
  - cmd_valid = not empty. cmd_id and cmd_long show the head and are registered.
  - Pop occurs on cmd_valid & cmd_ready.
  - Push and pop in the same cycle are both allowed when the FIFO is not full.
  - When full, pending flags hold, so there is no loss until a second event hits the same flag.
  - Head stays stable while cmd_valid=1 and cmd_ready=0.
- clr_err clears dropped at the next edge. If a drop occurs in the same cycle, dropped stays 1 (set wins).
- Reset asserted mid-operation clears the FIFO immediately. Buttons held at reset release need re-press.

Test Plan:
All scenarios use NUM_BTN=4, LONG_CNT=8, FIFO_DEPTH=4 unless noted.
1. Hold btn_db[0]=1 through reset, release, wait 20 cycles → cmd_valid stays 0. Then press btn0 for 3 cycles with cmd_ready=1 → cmd_valid=1 for 1 cycle, cmd_id=0, cmd_long=0, 2 edges after the release edge.
2. Hold btn1 for 12 cycles → cmd_id=1, cmd_long=1, cmd_valid 2 edges after the 8th high sample. Release → no short command. A separate 7-cycle hold → short command (cmd_long=0).
3. Release btn3, btn1, btn2, btn0 in the same cycle, cmd_ready=1, rr=0 → commands in id order 0,1,2,3 on consecutive cycles; rr ends at 0.
4. cmd_ready=0: short presses on btn0,1,2,3 then btn0 again → 4 entries held, head (id 0) stable, short_pend[0] set. Press btn0 once more → dropped=1. Set cmd_ready=1 → 5 commands drained; final command id 0.
5. Assert rst while cmd_valid=1 and a pending flag is set → cmd_valid=0 asynchronously. After reset release with no button activity → no commands.
6. Pulse clr_err with no drop → dropped=0 next edge. Pulse clr_err in the same cycle as a drop → dropped remains 1.
